// File: rtl/arb2_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb2_stream_pkg
// Description : Shared types and constants for the two-source stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb2_stream_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int WIDTH_DEFAULT = 8;

endpackage : arb2_stream_pkg
`default_nettype wire

// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
// Module      : mux2_1
// Description : WIDTH-wide 2:1 multiplexer, i_sel=0 selects i_d0.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule : mux2_1
`default_nettype wire

// File: rtl/arb2_stream.sv
`default_nettype none
// ============================================================================
// Module      : arb2_stream
// Description : Round-robin merge of two valid/ready streams into one
//               registered output stage with 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_stream
    import arb2_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_sel;
    logic             r_sel;
    logic [WIDTH-1:0] r_y_data;

    logic             w_can_load;
    logic             w_grant;
    logic             w_grant_valid;
    logic             w_load;
    logic [WIDTH-1:0] w_mux_data;

    // Tie goes to the source that did not win the last accepted beat
    always_comb begin
        w_grant_valid = a_valid | b_valid;
        if (a_valid && b_valid) begin
            w_grant = ~r_last_sel;
        end else if (b_valid) begin
            w_grant = SRC_B;
        end else begin
            w_grant = SRC_A;
        end
    end

    mux2_1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_d0  (a_data),
        .i_d1  (b_data),
        .i_sel (w_grant),
        .o_y   (w_mux_data)
    );

    always_comb begin
        w_next_state = r_state;
        w_can_load   = 1'b0;
        w_load       = 1'b0;
        a_ready      = 1'b0;
        b_ready      = 1'b0;

        w_can_load = (r_state == EMPTY) || y_ready;
        w_load     = rst_n && w_can_load && w_grant_valid;
        a_ready    = w_load && (w_grant == SRC_A);
        b_ready    = w_load && (w_grant == SRC_B);

        case (r_state)
            EMPTY: begin
                if (w_load) begin
                    w_next_state = FULL;
                end
            end
            FULL: begin
                if (y_ready && !w_load) begin
                    w_next_state = EMPTY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // last_sel resets to B so that the very first tie is won by A
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_data   <= '0;
            r_sel      <= SRC_A;
            r_last_sel <= SRC_B;
        end else if (w_load) begin
            r_y_data   <= w_mux_data;
            r_sel      <= w_grant;
            r_last_sel <= w_grant;
        end
    end

    assign y_data  = r_y_data;
    assign y_valid = (r_state == FULL);
    assign sel     = r_sel;

endmodule : arb2_stream
`default_nettype wire

// File: tb/tb_arb2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb2_stream
// Description : Directed vector bench for arb2_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb2_stream;

    localparam int WIDTH = 8;

    typedef struct {
        logic       rst_n;
        logic       a_valid;
        logic [7:0] a_data;
        logic       b_valid;
        logic [7:0] b_data;
        logic       y_ready;
        logic       exp_a_ready;
        logic       exp_b_ready;
        logic       exp_y_valid;
        logic [7:0] exp_y_data;
        logic       exp_sel;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             sel;

    int total;
    int bad;
    logic seen_44;

    arb2_stream #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any consumed beat carrying 0x44 means a pre-reset beat leaked out
    always @(posedge clk) begin
        if (y_valid === 1'b1 && y_ready === 1'b1 && y_data === 8'h44) begin
            seen_44 <= 1'b1;
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, check readies before the edge, registered outputs after it
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n   = v.rst_n;
        a_valid = v.a_valid;
        a_data  = v.a_data;
        b_valid = v.b_valid;
        b_data  = v.b_data;
        y_ready = v.y_ready;
        #1;
        check("a_ready", idx, {31'd0, a_ready}, {31'd0, v.exp_a_ready});
        check("b_ready", idx, {31'd0, b_ready}, {31'd0, v.exp_b_ready});
        @(posedge clk);
        #1;
        check("y_valid", idx, {31'd0, y_valid}, {31'd0, v.exp_y_valid});
        check("y_data",  idx, {24'd0, y_data},  {24'd0, v.exp_y_data});
        check("sel",     idx, {31'd0, sel},     {31'd0, v.exp_sel});
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd, input logic yr,
                                input logic ear, input logic ebr, input logic eyv,
                                input logic [7:0] eyd, input logic esel);
        vec_t v;
        v.rst_n = r;   v.a_valid = av; v.a_data = ad;
        v.b_valid = bv; v.b_data = bd; v.y_ready = yr;
        v.exp_a_ready = ear; v.exp_b_ready = ebr;
        v.exp_y_valid = eyv; v.exp_y_data = eyd; v.exp_sel = esel;
        return v;
    endfunction

    vec_t table_v[15];

    initial begin
        total   = 0;
        bad     = 0;
        seen_44 = 1'b0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        y_ready = 1'b0;

        //                  rst av ad     bv bd     yr  ar br  yv yd     sel
        // reset with both sources valid
        table_v[0]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  0, 0,  0, 8'h00, 0);
        table_v[1]  = mk(0, 1, 8'h11, 1, 8'h22, 1,  0, 0,  0, 8'h00, 0);
        // sustained tie alternates A, B, A, B
        table_v[2]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0);
        table_v[3]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1);
        table_v[4]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0);
        table_v[5]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1);
        // drain to empty, data held
        table_v[6]  = mk(1, 0, 8'h11, 0, 8'h22, 1,  0, 0,  0, 8'h22, 1);
        // single source B streaming
        table_v[7]  = mk(1, 0, 8'h11, 1, 8'h5A, 1,  0, 1,  1, 8'h5A, 1);
        table_v[8]  = mk(1, 0, 8'h11, 1, 8'h5A, 1,  0, 1,  1, 8'h5A, 1);
        // load 0x33 from A then backpressure three cycles
        table_v[9]  = mk(1, 1, 8'h33, 0, 8'h5A, 1,  1, 0,  1, 8'h33, 0);
        table_v[10] = mk(1, 1, 8'h33, 1, 8'h22, 0,  0, 0,  1, 8'h33, 0);
        table_v[11] = mk(1, 1, 8'h33, 1, 8'h22, 0,  0, 0,  1, 8'h33, 0);
        table_v[12] = mk(1, 1, 8'h33, 1, 8'h22, 0,  0, 0,  1, 8'h33, 0);
        // release: drain and load B in the same cycle
        table_v[13] = mk(1, 1, 8'h33, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1);
        table_v[14] = mk(1, 0, 8'h33, 0, 8'h22, 1,  0, 0,  0, 8'h22, 1);

        for (int i = 0; i < 15; i++) begin
            apply(table_v[i], i);
        end

        // Reset mid-stream while holding 0x44, then first tie goes to A again
        apply(mk(1, 1, 8'h44, 0, 8'h00, 1,  1, 0,  1, 8'h44, 0), 100);
        apply(mk(1, 0, 8'h44, 0, 8'h00, 0,  0, 0,  1, 8'h44, 0), 101);
        apply(mk(0, 0, 8'h44, 0, 8'h00, 0,  0, 0,  0, 8'h00, 0), 102);
        apply(mk(1, 0, 8'h44, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0), 103);
        apply(mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 0), 104);
        apply(mk(1, 0, 8'h11, 0, 8'h22, 1,  0, 0,  0, 8'h11, 0), 105);
        check("no_0x44_emitted", 106, {31'd0, seen_44}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arb2_stream
`default_nettype wire

// File: doc/arb2_stream.md
ARB2_STREAM -- requirements
Module: arb2_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width of both inputs and the output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 a_data  input  WIDTH  source A beat.
REQ-005 a_valid  input  1  source A beat present.
REQ-006 a_ready  output  1  source A beat accepted this cycle when high together with a_valid.
REQ-007 b_data  input  WIDTH  source B beat.
REQ-008 b_valid  input  1  source B beat present.
REQ-009 b_ready  output  1  source B beat accepted this cycle when high together with b_valid.
REQ-010 y_data  output  WIDTH  registered output beat.
REQ-011 y_valid  output  1  y_data holds a beat.
REQ-012 y_ready  input  1  consumer takes the beat when high with y_valid.
REQ-013 sel  output  1  source of the current y beat: 0 = A, 1 = B; registered with y_data.

Function
REQ-014 The block SHALL have two states: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-015 can_load SHALL be high in EMPTY, or in FULL with y_ready=1.
REQ-016 Grant: only A valid -> A; only B valid -> B; both valid -> the source not equal to last_sel; neither -> no grant.
REQ-017 a_ready SHALL equal can_load AND grant=A; b_ready SHALL equal can_load AND grant=B; never both high.
REQ-018 a_ready/b_ready SHALL depend only on registered state, a_valid, b_valid and y_ready (no path from data).
REQ-019 On a handshake, y_data SHALL load the granted data, sel and last_sel the granted source, y_valid SHALL be 1 next cycle.
REQ-020 Latency SHALL be exactly 1 cycle from input handshake to y_valid; sustained throughput SHALL be 1 beat/cycle.
REQ-021 FULL with y_ready=1 and no grant SHALL go to EMPTY; FULL with y_ready=1 and a grant SHALL stay FULL with the new beat (simultaneous drain and load).
REQ-022 FULL with y_ready=0 SHALL hold y_data, sel, y_valid unchanged and assert neither input ready.
REQ-023 last_sel SHALL change only on an input handshake, so a waiting source is granted at the latest on the second accepted beat.
REQ-024 Input valid dropping without handshake SHALL not alter grant state.

Reset
REQ-025 With rst_n=0 at a clk edge: y_valid=0, y_data=0, sel=0, last_sel=1 (A wins first tie), state EMPTY.
REQ-026 During reset a_ready and b_ready SHALL be 0.
REQ-027 Reset mid-operation SHALL discard a held beat; no beat SHALL be emitted that was accepted before reset.

Structure
REQ-028 Shared package SHALL hold the state type (EMPTY/FULL), the source encoding constants SRC_A=0 / SRC_B=1 and the WIDTH default.
REQ-029 Data selection SHALL instantiate the existing 2:1 multiplexer mux2_1 (one per bit or WIDTH-wide variant), with sel driven by the grant.
REQ-030 No other sub-modules; state, grant and output register in arb2_stream.

Verification
REQ-031 Reset: rst_n=0 two cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, y_valid=0, y_data=0, sel=0.
REQ-032 Tie: a_data=0x11, b_data=0x22, both valid, y_ready=1 for 4 cycles -> y sequence 0x11(sel0), 0x22(sel1), 0x11, 0x22, one per cycle from cycle 1.
REQ-033 Single source: only b_valid, b_data=0x5A, y_ready=1 -> b_ready=1 every cycle, y_data=0x5A, sel=1 after 1 cycle.
REQ-034 Backpressure: load 0x33 from A, hold y_ready=0 3 cycles -> y_data=0x33, y_valid=1 stable, a_ready=b_ready=0; release -> beat consumed, next beat loaded same cycle.
REQ-035 Drain to empty: FULL, y_ready=1, no valid inputs -> y_valid=0 next cycle, y_data unchanged.
REQ-036 Reset mid-stream: FULL holding 0x44, rst_n=0 one cycle -> y_valid=0, 0x44 never observed on a y handshake.
